// File: rtl/axi_ddr3_tester.sv
// axi_ddr3_tester
//   AXI4 initiator used for DDR3 bring-up and built-in self-test. On start it
//   writes NUM_BURSTS INCR bursts of a seeded pattern, reads them back, and
//   compares every beat. At most one burst is in flight at any time.
//
// Ports
//   clock, arst_n        system clock, asynchronous active-low reset
//   start_i              begin a pass (only honoured while idle)
//   busy_o               pass in progress
//   done_o               pass finished; held until the next accepted start
//   pass_o               done_o with a zero error count
//   errors_o             saturating error count for the current/last pass
//   err_addr_o           byte address of the first error of the pass
//   axi_aw*/axi_w*       write address / write data channels (initiator side)
//   axi_b*               write response channel
//   axi_ar*/axi_r*       read address / read data channels
module axi_ddr3_tester #(
    parameter int          ADDRS      = 29,
    parameter int          WIDTH      = 32,
    parameter int          MASKS      = 4,
    parameter int          ID_WIDTH   = 4,
    parameter int          TXN_ID     = 0,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 64,
    parameter logic [63:0] START_ADDR = 64'h0,
    parameter logic [31:0] SEED       = 32'h5A5A_0000
) (
    input  logic                clock,
    input  logic                arst_n,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [15:0]         errors_o,
    output logic [ADDRS-1:0]    err_addr_o,
    output logic                axi_awvalid_o,
    input  logic                axi_awready_i,
    output logic [ADDRS-1:0]    axi_awaddr_o,
    output logic [ID_WIDTH-1:0] axi_awid_o,
    output logic [7:0]          axi_awlen_o,
    output logic [1:0]          axi_awburst_o,
    output logic                axi_wvalid_o,
    input  logic                axi_wready_i,
    output logic                axi_wlast_o,
    output logic [MASKS-1:0]    axi_wstrb_o,
    output logic [WIDTH-1:0]    axi_wdata_o,
    input  logic                axi_bvalid_i,
    output logic                axi_bready_o,
    input  logic [1:0]          axi_bresp_i,
    input  logic [ID_WIDTH-1:0] axi_bid_i,
    output logic                axi_arvalid_o,
    input  logic                axi_arready_i,
    output logic [ADDRS-1:0]    axi_araddr_o,
    output logic [ID_WIDTH-1:0] axi_arid_o,
    output logic [7:0]          axi_arlen_o,
    output logic [1:0]          axi_arburst_o,
    input  logic                axi_rvalid_i,
    output logic                axi_rready_o,
    input  logic                axi_rlast_i,
    input  logic [1:0]          axi_rresp_i,
    input  logic [ID_WIDTH-1:0] axi_rid_i,
    input  logic [WIDTH-1:0]    axi_rdata_i
);

    localparam int BYTES   = WIDTH / 8;
    localparam int BEAT_W  = $clog2(BURST_LEN + 1);
    localparam int BURST_W = $clog2(NUM_BURSTS + 1);

    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]  LAST_BURST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [ADDRS-1:0]    BASE       = ADDRS'(START_ADDR);
    localparam logic [ADDRS-1:0]    BEAT_STEP  = ADDRS'(BYTES);
    localparam logic [ADDRS-1:0]    BURST_STEP = ADDRS'(BURST_LEN * BYTES);
    localparam logic [ID_WIDTH-1:0] ID         = ID_WIDTH'(TXN_ID);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q;
    logic [BURST_W-1:0]   burst_q;
    logic [ADDRS-1:0]     burst_addr_q;
    logic                 busy_q, done_q;
    logic [15:0]          errors_q;
    logic [ADDRS-1:0]     err_addr_q;

    logic                 last_beat, last_burst;
    logic [31:0]          beat_k;
    logic [WIDTH-1:0]     pattern;
    logic [ADDRS-1:0]     beat_addr;
    logic                 b_bad, r_data_bad, r_frame_bad, r_end;
    logic [1:0]           err_inc;
    logic [16:0]          err_sum;
    logic [15:0]          err_sat;

    // The global beat index is rebuilt from burst/beat counters so an early
    // rlast never desynchronises the expected pattern of the next burst.
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);
    assign beat_k     = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q);
    assign pattern    = {(WIDTH / 32){beat_k ^ SEED}};
    assign beat_addr  = burst_addr_q + ADDRS'(beat_q) * BEAT_STEP;

    assign b_bad       = (axi_bresp_i != 2'b00) || (axi_bid_i != ID);
    assign r_data_bad  = (axi_rdata_i != pattern) || (axi_rresp_i != 2'b00) || (axi_rid_i != ID);
    assign r_frame_bad = (axi_rlast_i != last_beat);
    assign r_end       = axi_rlast_i || last_beat;

    // A read beat can carry both a data error and a framing error.
    always_comb begin
        err_inc = 2'd0;
        if (state_q == S_B && axi_bvalid_i)
            err_inc = {1'b0, b_bad};
        else if (state_q == S_R && axi_rvalid_i)
            err_inc = {1'b0, r_data_bad} + {1'b0, r_frame_bad};
    end

    assign err_sum = {1'b0, errors_q} + {15'd0, err_inc};
    assign err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    // State register.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; every handshake is qualified by the registered state,
    // so the valid/ready outputs below never depend on the partner's signals.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i)                     state_d = S_AW;
            S_AW:   if (axi_awready_i)               state_d = S_W;
            S_W:    if (axi_wready_i && last_beat)   state_d = S_B;
            S_B:    if (axi_bvalid_i)                state_d = last_burst ? S_AR : S_AW;
            S_AR:   if (axi_arready_i)               state_d = S_R;
            S_R:    if (axi_rvalid_i && r_end)       state_d = last_burst ? S_DONE : S_AR;
            S_DONE:                                  state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
        endcase
    end

    // Counters, status flags and error capture.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            errors_q     <= 16'd0;
            err_addr_q   <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            burst_addr_q <= '0;
        end else begin
            if (err_inc != 2'd0) begin
                errors_q <= err_sat;
                if (errors_q == 16'd0)
                    err_addr_q <= (state_q == S_B) ? burst_addr_q : beat_addr;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        errors_q     <= 16'd0;
                        err_addr_q   <= '0;
                        beat_q       <= '0;
                        burst_q      <= '0;
                        burst_addr_q <= BASE;
                    end
                end
                S_W: begin
                    if (axi_wready_i)
                        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                end
                S_B: begin
                    if (axi_bvalid_i) begin
                        beat_q <= '0;
                        if (last_burst) begin
                            burst_q      <= '0;
                            burst_addr_q <= BASE;
                        end else begin
                            burst_q      <= burst_q + BURST_W'(1);
                            burst_addr_q <= burst_addr_q + BURST_STEP;
                        end
                    end
                end
                S_R: begin
                    if (axi_rvalid_i) begin
                        if (r_end) begin
                            beat_q <= '0;
                            if (last_burst) begin
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                burst_q      <= '0;
                                burst_addr_q <= BASE;
                            end else begin
                                burst_q      <= burst_q + BURST_W'(1);
                                burst_addr_q <= burst_addr_q + BURST_STEP;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = done_q && (errors_q == 16'd0);
    assign errors_o      = errors_q;
    assign err_addr_o    = err_addr_q;

    assign axi_awvalid_o = (state_q == S_AW);
    assign axi_awaddr_o  = burst_addr_q;
    assign axi_awid_o    = ID;
    assign axi_awlen_o   = 8'(BURST_LEN - 1);
    assign axi_awburst_o = 2'b01;

    assign axi_wvalid_o  = (state_q == S_W);
    assign axi_wlast_o   = (state_q == S_W) && last_beat;
    assign axi_wstrb_o   = '1;
    assign axi_wdata_o   = (state_q == S_W) ? pattern : '0;

    assign axi_bready_o  = (state_q == S_B);

    assign axi_arvalid_o = (state_q == S_AR);
    assign axi_araddr_o  = burst_addr_q;
    assign axi_arid_o    = ID;
    assign axi_arlen_o   = 8'(BURST_LEN - 1);
    assign axi_arburst_o = 2'b01;

    assign axi_rready_o  = (state_q == S_R);

endmodule

// File: tb/tb_axi_ddr3_tester.sv
// tb_axi_ddr3_tester
//   Drives the self-test initiator against a small memory-backed AXI responder
//   with random stalls and injectable faults, and compares the initiator's
//   traffic and final status with a behavioural model of one test pass.
module tb_axi_ddr3_tester;

    localparam int          ADDRS    = 29;
    localparam int          WIDTH    = 32;
    localparam int          MASKS    = 4;
    localparam int          ID_WIDTH = 4;
    localparam int          TXN_ID   = 3;
    localparam int          BL       = 4;
    localparam int          NB       = 3;
    localparam int          TOTAL    = NB * BL;
    localparam logic [63:0] START    = 64'h100;
    localparam logic [31:0] SEED     = 32'h5A5A_0000;

    logic                clock = 1'b0;
    logic                arst_n = 1'b0;
    logic                start = 1'b0;
    logic                busy, done, pass_flag;
    logic [15:0]         dut_errors;
    logic [ADDRS-1:0]    err_addr;
    logic                axi_awvalid, axi_awready = 1'b0;
    logic [ADDRS-1:0]    axi_awaddr;
    logic [ID_WIDTH-1:0] axi_awid;
    logic [7:0]          axi_awlen;
    logic [1:0]          axi_awburst;
    logic                axi_wvalid, axi_wready = 1'b0, axi_wlast;
    logic [MASKS-1:0]    axi_wstrb;
    logic [WIDTH-1:0]    axi_wdata;
    logic                axi_bvalid = 1'b0, axi_bready;
    logic [1:0]          axi_bresp = 2'b00;
    logic [ID_WIDTH-1:0] axi_bid = '0;
    logic                axi_arvalid, axi_arready = 1'b0;
    logic [ADDRS-1:0]    axi_araddr;
    logic [ID_WIDTH-1:0] axi_arid;
    logic [7:0]          axi_arlen;
    logic [1:0]          axi_arburst;
    logic                axi_rvalid = 1'b0, axi_rready, axi_rlast = 1'b0;
    logic [1:0]          axi_rresp = 2'b00;
    logic [ID_WIDTH-1:0] axi_rid = '0;
    logic [WIDTH-1:0]    axi_rdata = '0;

    int check_count = 0;
    int fail_count  = 0;

    // fault / stall knobs for the current pass
    int ready_pct   = 100;
    int bad_b_burst = -1;
    int early_burst = -1;
    int early_beat  = -1;
    bit corrupt [TOTAL];

    // responder bookkeeping
    int               aw_count, w_count, b_count, ar_count, r_count;
    logic [31:0]      mem [256];
    bit               b_pend, b_fire, r_fire;
    int               r_left, r_beat, r_burst, r_idx;
    logic [ADDRS-1:0] w_addr, r_addr;
    bit               aw_stall, w_stall, ar_stall;
    logic [ADDRS-1:0] aw_saved, ar_saved;
    logic [31:0]      w_saved;
    logic             wlast_saved;
    bit               seen_w;
    int               n_bad, ri;

    axi_ddr3_tester #(
        .ADDRS(ADDRS), .WIDTH(WIDTH), .MASKS(MASKS), .ID_WIDTH(ID_WIDTH),
        .TXN_ID(TXN_ID), .BURST_LEN(BL), .NUM_BURSTS(NB),
        .START_ADDR(START), .SEED(SEED)
    ) dut (
        .clock(clock), .arst_n(arst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass_flag),
        .errors_o(dut_errors), .err_addr_o(err_addr),
        .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready), .axi_awaddr_o(axi_awaddr),
        .axi_awid_o(axi_awid), .axi_awlen_o(axi_awlen), .axi_awburst_o(axi_awburst),
        .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready), .axi_wlast_o(axi_wlast),
        .axi_wstrb_o(axi_wstrb), .axi_wdata_o(axi_wdata),
        .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready), .axi_bresp_i(axi_bresp),
        .axi_bid_i(axi_bid),
        .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready), .axi_araddr_o(axi_araddr),
        .axi_arid_o(axi_arid), .axi_arlen_o(axi_arlen), .axi_arburst_o(axi_arburst),
        .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready), .axi_rlast_i(axi_rlast),
        .axi_rresp_i(axi_rresp), .axi_rid_i(axi_rid), .axi_rdata_i(axi_rdata)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit chance();
        return (int'($urandom_range(99)) < ready_pct);
    endfunction

    // Expected outcome of one pass: B errors come first in time, then read
    // beats in address order; an early rlast ends that burst's reads.
    task automatic model_pass(output int exp_err, output logic [63:0] exp_addr, output int exp_r);
        exp_err  = 0;
        exp_addr = 64'h0;
        exp_r    = 0;
        if (bad_b_burst >= 0) begin
            exp_err  = 1;
            exp_addr = START + 64'(bad_b_burst * BL * 4);
        end
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < BL; j++) begin
                logic [63:0] a;
                a = START + 64'((b * BL + j) * 4);
                exp_r++;
                if (corrupt[b * BL + j]) begin
                    if (exp_err == 0) exp_addr = a;
                    exp_err++;
                end
                if (b == early_burst && j == early_beat && j != BL - 1) begin
                    if (exp_err == 0) exp_addr = a;
                    exp_err++;
                    break;
                end
            end
        end
    endtask

    task automatic reset_responder();
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_bvalid  = 1'b0; axi_rvalid = 1'b0; axi_rlast   = 1'b0;
        b_pend = 0; b_fire = 0; r_fire = 0; r_left = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
    endtask

    // Responder and per-cycle compare: decides readiness on the falling edge,
    // so a handshake seen here is the one the DUT takes at the next rising edge.
    always @(negedge clock) begin
        if (!arst_n) begin
            reset_responder();
        end else begin
            if (aw_stall) begin
                checkOutput("aw_hold_valid", 64'(axi_awvalid), 64'd1);
                checkOutput("aw_hold_addr", 64'(axi_awaddr), 64'(aw_saved));
            end
            if (w_stall) begin
                checkOutput("w_hold_valid", 64'(axi_wvalid), 64'd1);
                checkOutput("w_hold_data", 64'(axi_wdata), 64'(w_saved));
                checkOutput("w_hold_last", 64'(axi_wlast), 64'(wlast_saved));
            end
            if (ar_stall) begin
                checkOutput("ar_hold_valid", 64'(axi_arvalid), 64'd1);
                checkOutput("ar_hold_addr", 64'(axi_araddr), 64'(ar_saved));
            end
            if (b_fire) begin axi_bvalid = 1'b0; b_fire = 0; end
            if (r_fire) begin axi_rvalid = 1'b0; axi_rlast = 1'b0; r_fire = 0; end

            if (b_pend && !axi_bvalid && chance()) begin
                axi_bvalid = 1'b1;
                axi_bresp  = (b_count == bad_b_burst) ? 2'b10 : 2'b00;
                axi_bid    = ID_WIDTH'(TXN_ID);
            end
            if (axi_bvalid && axi_bready) begin
                b_fire = 1; b_pend = 0; b_count++;
            end

            axi_awready = chance();
            if (axi_awvalid && axi_awready) begin
                checkOutput("aw_addr", 64'(axi_awaddr), START + 64'(aw_count * BL * 4));
                checkOutput("aw_len", 64'(axi_awlen), 64'(BL - 1));
                checkOutput("aw_burst", 64'(axi_awburst), 64'd1);
                checkOutput("aw_id", 64'(axi_awid), 64'(TXN_ID));
                checkOutput("aw_one_outstanding", 64'(b_count), 64'(aw_count));
                w_addr = axi_awaddr;
                aw_count++;
            end
            aw_stall = axi_awvalid && !axi_awready;
            aw_saved = axi_awaddr;

            axi_wready = chance();
            if (axi_wvalid && axi_wready) begin
                checkOutput("w_data", 64'(axi_wdata), 64'(32'(w_count) ^ SEED));
                checkOutput("w_last", 64'(axi_wlast), 64'((w_count % BL) == BL - 1));
                checkOutput("w_strb", 64'(axi_wstrb), 64'hF);
                mem[w_addr[9:2]] = axi_wdata;
                w_addr = w_addr + ADDRS'(4);
                if (axi_wlast) b_pend = 1;
                w_count++;
            end
            w_stall     = axi_wvalid && !axi_wready;
            w_saved     = axi_wdata;
            wlast_saved = axi_wlast;

            if (r_left > 0 && !axi_rvalid && chance()) begin
                r_idx      = r_burst * BL + r_beat;
                axi_rvalid = 1'b1;
                axi_rdata  = mem[r_addr[9:2]] ^ {31'd0, corrupt[r_idx]};
                axi_rlast  = (r_beat == BL - 1) || (r_burst == early_burst && r_beat == early_beat);
                axi_rresp  = 2'b00;
                axi_rid    = ID_WIDTH'(TXN_ID);
            end
            if (axi_rvalid && axi_rready) begin
                r_fire = 1;
                r_count++;
                if (axi_rlast) begin
                    r_left = 0;
                end else begin
                    r_left--; r_beat++;
                    r_addr = r_addr + ADDRS'(4);
                end
            end

            axi_arready = chance();
            if (axi_arvalid && axi_arready) begin
                checkOutput("ar_addr", 64'(axi_araddr), START + 64'(ar_count * BL * 4));
                checkOutput("ar_len", 64'(axi_arlen), 64'(BL - 1));
                checkOutput("ar_burst", 64'(axi_arburst), 64'd1);
                checkOutput("ar_id", 64'(axi_arid), 64'(TXN_ID));
                checkOutput("ar_after_writes", 64'(b_count), 64'(NB));
                checkOutput("ar_one_outstanding", 64'(r_left), 64'd0);
                r_left  = BL; r_beat = 0; r_burst = ar_count;
                r_addr  = axi_araddr;
                ar_count++;
            end
            ar_stall = axi_arvalid && !axi_arready;
            ar_saved = axi_araddr;
        end
    end

    task automatic clear_counters();
        aw_count = 0; w_count = 0; b_count = 0; ar_count = 0; r_count = 0;
    endtask

    // Runs one complete pass with the given stall rate and faults and checks
    // the final status against the model.
    task automatic applyStimulus(input int pct, input int bad_b, input int e_burst,
                                 input int e_beat, input string tag);
        int          exp_err, exp_r;
        logic [63:0] exp_addr;
        bit          seen;
        ready_pct = pct; bad_b_burst = bad_b; early_burst = e_burst; early_beat = e_beat;
        clear_counters();
        model_pass(exp_err, exp_addr, exp_r);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        checkOutput({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        checkOutput({tag, "_done_cleared"}, 64'(done), 64'd0);
        checkOutput({tag, "_errors_cleared"}, 64'(dut_errors), 64'd0);
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clock);
            start = (c == 5 && busy) ? 1'b1 : 1'b0;
            seen  = done;
        end
        start = 1'b0;
        checkOutput({tag, "_done_in_time"}, 64'(seen), 64'd1);
        checkOutput({tag, "_errors"}, 64'(dut_errors), 64'(exp_err));
        checkOutput({tag, "_err_addr"}, 64'(err_addr), exp_addr);
        checkOutput({tag, "_pass"}, 64'(pass_flag), 64'(exp_err == 0));
        checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
        checkOutput({tag, "_aw_bursts"}, 64'(aw_count), 64'(NB));
        checkOutput({tag, "_w_beats"}, 64'(w_count), 64'(TOTAL));
        checkOutput({tag, "_ar_bursts"}, 64'(ar_count), 64'(NB));
        checkOutput({tag, "_r_beats"}, 64'(r_count), 64'(exp_r));
        repeat (3) @(negedge clock);
        checkOutput({tag, "_done_held"}, 64'(done), 64'd1);
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < TOTAL; i++) corrupt[i] = 1'b0;
    endtask

    initial begin
        clear_corrupt();
        clear_counters();
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_pass", 64'(pass_flag), 64'd0);
        checkOutput("rst_errors", 64'(dut_errors), 64'd0);
        checkOutput("rst_err_addr", 64'(err_addr), 64'd0);
        checkOutput("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}), 64'd0);
        #1 arst_n = 1'b1;

        $display("[TB] ideal responder");
        applyStimulus(100, -1, -1, -1, "ideal");
        checkOutput("ideal_pass_literal", 64'(pass_flag), 64'd1);

        $display("[TB] random stalls");
        applyStimulus(50, -1, -1, -1, "stall_a");
        applyStimulus(35, -1, -1, -1, "stall_b");

        $display("[TB] corrupted read beat 5");
        clear_corrupt();
        corrupt[5] = 1'b1;
        applyStimulus(100, -1, -1, -1, "corrupt");
        checkOutput("corrupt_errors_literal", 64'(dut_errors), 64'd1);
        checkOutput("corrupt_addr_literal", 64'(err_addr), 64'h114);
        checkOutput("corrupt_pass_literal", 64'(pass_flag), 64'd0);

        $display("[TB] bad write response on burst 1");
        clear_corrupt();
        applyStimulus(70, 1, -1, -1, "bresp");
        checkOutput("bresp_errors_literal", 64'(dut_errors), 64'd1);
        checkOutput("bresp_addr_literal", 64'(err_addr), 64'h110);
        checkOutput("bresp_reads_literal", 64'(r_count), 64'd12);

        $display("[TB] early rlast on beat 2");
        applyStimulus(100, -1, 0, 2, "early");
        checkOutput("early_errors_literal", 64'(dut_errors), 64'd1);
        checkOutput("early_addr_literal", 64'(err_addr), 64'h108);
        checkOutput("early_ar_literal", 64'(ar_count), 64'd3);

        $display("[TB] randomized passes");
        for (int it = 0; it < 6; it++) begin
            clear_corrupt();
            n_bad = int'($urandom_range(2));
            for (int m = 0; m < n_bad; m++) begin
                ri = int'($urandom_range(TOTAL - 1));
                corrupt[ri] = 1'b1;
            end
            applyStimulus(int'($urandom_range(100, 30)),
                          ($urandom_range(3) == 0) ? int'($urandom_range(NB - 1)) : -1,
                          -1, -1, "rand");
        end

        $display("[TB] reset during write data");
        clear_corrupt();
        ready_pct = 60; bad_b_burst = -1; early_burst = -1; early_beat = -1;
        clear_counters();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        seen_w = 0;
        for (int c = 0; c < 200 && !seen_w; c++) begin
            @(negedge clock);
            seen_w = axi_wvalid;
        end
        checkOutput("rst_mid_reached_w", 64'(seen_w), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_done", 64'(done), 64'd0);
        repeat (3) @(negedge clock);
        #1 arst_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_release_done", 64'(done), 64'd0);
        checkOutput("rst_release_busy", 64'(busy), 64'd0);
        checkOutput("rst_release_errors", 64'(dut_errors), 64'd0);
        applyStimulus(100, -1, -1, -1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", check_count, fail_count);
        $finish;
    end

endmodule
